hex_display_scheduler: RTL and testbench

Write-arbitration and refresh controller for the six on-board HEX displays. It accepts digit writes from two requesters over valid/ready handshakes, arbitrating between them round-robin, and stores six 4-bit digit values. A single shared hex-to-segment decoder is time-shared across all six displays: a scan FSM decodes only changed digits into registered HEX outputs. It sits between application logic and the HEX0–HEX5 pins in `main`.

---
 rtl/hex_display_scheduler_if.sv | 37 +++
 rtl/hex_display_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_hex_display_scheduler.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hex_display_scheduler_if.sv
// ---------------------------------------------------------------------------
// hex_display_scheduler_if
//   Bundles the two digit-write requesters that feed hex_display_scheduler.
//   Each requester presents valid/idx/data and receives ready. A write is
//   accepted on a rising clock edge when valid and ready are both high.
//
//   Signals (per requester n = 0,1):
//     reqn_valid  write pending
//     reqn_idx    target digit 0..5 (6 and 7 are accepted and ignored)
//     reqn_data   hex value to show
//     reqn_ready  write accepted this cycle
//
//   Modports: master (application side), slave (scheduler side).
// ---------------------------------------------------------------------------
interface hex_display_scheduler_if;
    logic       req0_valid;
    logic [2:0] req0_idx;
    logic [3:0] req0_data;
    logic       req0_ready;

    logic       req1_valid;
    logic [2:0] req1_idx;
    logic [3:0] req1_data;
    logic       req1_ready;

    modport master (
        output req0_valid, req0_idx, req0_data,
        output req1_valid, req1_idx, req1_data,
        input  req0_ready, req1_ready
    );

    modport slave (
        input  req0_valid, req0_idx, req0_data,
        input  req1_valid, req1_idx, req1_data,
        output req0_ready, req1_ready
    );
endinterface

// File: rtl/hex_display_scheduler.sv
// ---------------------------------------------------------------------------
// hex_display_scheduler
//   Accepts digit writes from two round-robin arbitrated requesters, keeps
//   six 4-bit digits, and refreshes the six HEX displays through a single
//   shared hex-to-segment decoder. A scan FSM (IDLE/SCAN/COMMIT) visits the
//   digits in order and decodes only those marked dirty.
//
//   Ports:
//     CLOCK_50    system clock, all state on the rising edge
//     reset       synchronous, active-high
//     req         hex_display_scheduler_if.slave, two write requesters
//     blank_mask  per-digit blank (only when HEX_BLANK_EN is defined)
//     HEX0..HEX5  registered active-low segments, bit0 = a .. bit6 = g
//     busy        high whenever the scan FSM is not idle
//
//   Optional feature macro: HEX_BLANK_EN (per-digit blanking).
// ---------------------------------------------------------------------------
module hex_display_scheduler (
    input  logic                          CLOCK_50,
    input  logic                          reset,
    hex_display_scheduler_if.slave        req,
`ifdef HEX_BLANK_EN
    input  logic [5:0]                    blank_mask,
`endif
    output logic [6:0]                    HEX0,
    output logic [6:0]                    HEX1,
    output logic [6:0]                    HEX2,
    output logic [6:0]                    HEX3,
    output logic [6:0]                    HEX4,
    output logic [6:0]                    HEX5,
    output logic                          busy
);

    typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

    state_t     state, state_next;
    logic [3:0] digit [6];
    logic [6:0] hex_q [6];
    logic [5:0] dirty, dirty_next;
    logic [2:0] ptr, ptr_next;
    logic [3:0] dec_in;
    logic       last_grant;         // 0 = requester 0, 1 = requester 1

    logic       acc0, acc1, wr_en;
    logic [2:0] wr_idx;
    logic [3:0] wr_data;
    logic [5:0] wr_onehot;
    logic [5:0] mask_set;
    logic       load_dec, do_commit;
    logic [6:0] commit_val;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        case (v)
            4'h0: return 7'h40;  4'h1: return 7'h79;
            4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;
            4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;
            4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;
            4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    function automatic logic [2:0] next_ptr(input logic [2:0] p);
        return (p == 3'd5) ? 3'd0 : p + 3'd1;
    endfunction

    // Round robin: on a tie the requester that did not win last time goes.
    assign req.req0_ready = !reset && req.req0_valid && (!req.req1_valid ||  last_grant);
    assign req.req1_ready = !reset && req.req1_valid && (!req.req0_valid || !last_grant);

    assign acc0    = req.req0_valid && req.req0_ready;
    assign acc1    = req.req1_valid && req.req1_ready;
    assign wr_en   = acc0 || acc1;
    assign wr_idx  = acc0 ? req.req0_idx  : req.req1_idx;
    assign wr_data = acc0 ? req.req0_data : req.req1_data;

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        wr_onehot = '0;
        if (wr_en && wr_idx < 3'd6)
            wr_onehot[wr_idx] = 1'b1;
    end

`ifdef HEX_BLANK_EN
    logic [5:0] mask_q;
    // A mask edge forces a redraw of that digit.
    assign mask_set   = blank_mask ^ mask_q;
    assign commit_val = mask_q[ptr] ? 7'h7F : hex_to_seg(dec_in);
`else
    assign mask_set   = '0;
    assign commit_val = hex_to_seg(dec_in);
`endif

    // Next-state and control for the scan FSM.
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        dirty_next = dirty;
        load_dec   = 1'b0;
        do_commit  = 1'b0;
        case (state)
            IDLE: begin
                if ((dirty | wr_onehot | mask_set) != 6'd0)
                    state_next = SCAN;
            end
            SCAN: begin
                if (dirty[ptr]) begin
                    load_dec   = 1'b1;
                    state_next = COMMIT;
                end else begin
                    ptr_next = next_ptr(ptr);
                    if (dirty == 6'd0)
                        state_next = IDLE;
                end
            end
            COMMIT: begin
                do_commit       = 1'b1;
                dirty_next[ptr] = 1'b0;
                ptr_next        = next_ptr(ptr);
                state_next      = SCAN;
            end
            default: state_next = IDLE;
        endcase
        // Applied last so a write landing on the committing digit keeps it dirty.
        dirty_next = dirty_next | wr_onehot | mask_set;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values and block ordering cannot matter.
    always_ff @(posedge CLOCK_50) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            ptr        <= 3'd0;
            dirty      <= 6'd0;
            dec_in     <= 4'd0;
            last_grant <= 1'b1;
            // NOTE: the digit store is a handful of flops, not a RAM, and its
            // reset contents are visible, so it is cleared with everything else.
            for (int i = 0; i < 6; i++) begin
                digit[i] <= 4'd0;
                hex_q[i] <= 7'h7F;
            end
`ifdef HEX_BLANK_EN
            mask_q     <= 6'd0;
`endif
        end else begin
            ptr   <= ptr_next;
            dirty <= dirty_next;
            // A write to the digit being snapshotted is forwarded; otherwise
            // its dirty bit would be cleared by the stale COMMIT.
            if (load_dec)
                dec_in <= wr_onehot[ptr] ? wr_data : digit[ptr];
            if (do_commit)
                hex_q[ptr] <= commit_val;
            if (wr_en && wr_idx < 3'd6)
                digit[wr_idx] <= wr_data;
            if (acc0)      last_grant <= 1'b0;
            else if (acc1) last_grant <= 1'b1;
`ifdef HEX_BLANK_EN
            mask_q <= blank_mask;
`endif
        end
    end

    assign HEX0 = hex_q[0];
    assign HEX1 = hex_q[1];
    assign HEX2 = hex_q[2];
    assign HEX3 = hex_q[3];
    assign HEX4 = hex_q[4];
    assign HEX5 = hex_q[5];
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_hex_display_scheduler.sv
// ---------------------------------------------------------------------------
// tb_hex_display_scheduler
//   Directed bench for hex_display_scheduler. Stimulus pushes the expected
//   display value of each write into a scoreboard; a monitor watches the HEX
//   outputs and pops/compares whenever a display changes. Timing, handshake
//   and reset behaviour are checked directly. Define HEX_BLANK_EN to include
//   the blanking sequence.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_hex_display_scheduler;

    logic       CLOCK_50 = 1'b0;
    logic       reset    = 1'b1;
    logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
    logic       busy;
`ifdef HEX_BLANK_EN
    logic [5:0] blank_mask = 6'd0;
`endif

    hex_display_scheduler_if bus ();

    hex_display_scheduler dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .req        (bus),
`ifdef HEX_BLANK_EN
        .blank_mask (blank_mask),
`endif
        .HEX0       (HEX0),
        .HEX1       (HEX1),
        .HEX2       (HEX2),
        .HEX3       (HEX3),
        .HEX4       (HEX4),
        .HEX5       (HEX5),
        .busy       (busy)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct packed {
        logic [2:0] idx;
        logic [6:0] seg;
    } exp_t;

    exp_t       exp_q[$];
    int         n_vec = 0;
    int         n_err = 0;
    logic [6:0] seg_tbl [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
        n_vec++;
        if (act !== req_v) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req_v, $time);
        end
    endtask

    function automatic logic [6:0] hex_of(input int n);
        case (n)
            0: return HEX0;
            1: return HEX1;
            2: return HEX2;
            3: return HEX3;
            4: return HEX4;
            default: return HEX5;
        endcase
    endfunction

    task automatic push_exp(input int n, input logic [6:0] seg);
        exp_t e;
        e.idx = n[2:0];
        e.seg = seg;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor: any display change must match the oldest pending
    // expectation for that digit.
    initial begin : monitor
        logic [6:0] prev [6];
        logic [6:0] cur;
        int         hit;
        for (int n = 0; n < 6; n++) prev[n] = 7'h7F;
        forever begin
            @(negedge CLOCK_50);
            #2;
            for (int n = 0; n < 6; n++) begin
                cur = hex_of(n);
                if (!reset && cur !== prev[n]) begin
                    hit = -1;
                    foreach (exp_q[k])
                        if (hit < 0 && exp_q[k].idx == n[2:0]) hit = k;
                    if (hit < 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL hex%0d_unexpected: got %02h, no change was due (t=%0t)", n, cur, $time);
                    end else begin
                        check($sformatf("hex%0d_update", n), 32'(cur), 32'(exp_q[hit].seg));
                        exp_q.delete(hit);
                    end
                end
                prev[n] = cur;
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "bench did not complete");
    end

    task automatic write_req(input bit port, input logic [2:0] idx, input logic [3:0] data);
        int n;
        @(negedge CLOCK_50);
        if (!port) begin
            bus.req0_valid = 1'b1; bus.req0_idx = idx; bus.req0_data = data;
        end else begin
            bus.req1_valid = 1'b1; bus.req1_idx = idx; bus.req1_data = data;
        end
        #1;
        n = 0;
        while (!(port ? bus.req1_ready : bus.req0_ready) && n < 50) begin
            @(negedge CLOCK_50);
            #1;
            n++;
        end
        check(port ? "req1_ready" : "req0_ready", port ? bus.req1_ready : bus.req0_ready, 1);
        @(posedge CLOCK_50);
        #1;
        if (!port) bus.req0_valid = 1'b0;
        else       bus.req1_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        do begin
            @(negedge CLOCK_50);
            #1;
            n++;
        end while (busy && n < 60);
        check(name, busy, 0);
    endtask

    task automatic wait_hex(input int idx, input logic [6:0] val, input int max, input string name);
        int n;
        n = 0;
        do begin
            @(negedge CLOCK_50);
            #1;
            n++;
        end while (hex_of(idx) !== val && n < max);
        check(name, hex_of(idx), val);
    endtask

    task automatic reset_dut();
        @(negedge CLOCK_50);
        reset = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_idx = 3'd0; bus.req0_data = 4'h9;
        repeat (2) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        #1;
        check("ready0_in_reset", bus.req0_ready, 0);
        for (int n = 0; n < 6; n++) check($sformatf("hex%0d_reset", n), hex_of(n), 7'h7F);
        check("busy_reset", busy, 0);
        bus.req0_valid = 1'b0;
        reset = 1'b0;
    endtask

    initial begin : stimulus
        logic exp_r0 [4];
        logic exp_r1 [4];
        seg_tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        exp_r0  = '{1'b1, 1'b0, 1'b1, 1'b0};
        exp_r1  = '{1'b0, 1'b1, 1'b0, 1'b1};
        bus.req0_valid = 1'b0; bus.req0_idx = 3'd0; bus.req0_data = 4'd0;
        bus.req1_valid = 1'b0; bus.req1_idx = 3'd0; bus.req1_data = 4'd0;

        // Reset and first write: HEX0 = 40 exactly two edges after acceptance.
        reset_dut();
        push_exp(0, 7'h40);
        write_req(0, 3'd0, 4'h0);
        @(negedge CLOCK_50); #1;
        check("first_hex0_t0", HEX0, 7'h7F);
        check("first_busy_t0", busy, 1);
        @(negedge CLOCK_50); #1;
        check("first_hex0_t1", HEX0, 7'h7F);
        @(negedge CLOCK_50); #1;
        check("first_hex0_t2", HEX0, 7'h40);
        check("first_busy_t2", busy, 1);
        @(negedge CLOCK_50); #1;
        check("first_busy_t3", busy, 0);

        // Full decode table through digit 3.
        for (int v = 0; v < 16; v++) begin
            push_exp(3, seg_tbl[v]);
            write_req(0, 3'd3, v[3:0]);
            wait_idle("table_idle");
        end
        check("table_drain", exp_q.size(), 0);

        // Out-of-range index: accepted, no display change, FSM stays idle.
        write_req(1, 3'd6, 4'h5);
        for (int k = 0; k < 3; k++) begin
            @(negedge CLOCK_50); #1;
            check("idx6_busy", busy, 0);
        end

        // Contention: requester 1 won last, so grants go 0,1,0,1.
        push_exp(1, 7'h24);
        push_exp(2, 7'h79);
        @(negedge CLOCK_50);
        bus.req0_valid = 1'b1; bus.req0_idx = 3'd1; bus.req0_data = 4'h2;
        bus.req1_valid = 1'b1; bus.req1_idx = 3'd2; bus.req1_data = 4'h1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("tie%0d_ready0", i), bus.req0_ready, exp_r0[i]);
            check($sformatf("tie%0d_ready1", i), bus.req1_ready, exp_r1[i]);
            @(negedge CLOCK_50);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        wait_idle("tie_idle");
        check("tie_hex1", HEX1, 7'h24);
        check("tie_hex2", HEX2, 7'h79);
        check("tie_drain", exp_q.size(), 0);

        // Collision: from reset, ptr=0, digit 4 commits six edges after its
        // write; a second write on that edge re-dirties it.
        reset_dut();
        push_exp(4, 7'h00);
        push_exp(4, 7'h0E);
        write_req(0, 3'd4, 4'h8);
        repeat (5) @(posedge CLOCK_50);
        write_req(0, 3'd4, 4'hF);
        @(negedge CLOCK_50); #1;
        check("collide_stale", HEX4, 7'h00);
        wait_hex(4, 7'h0E, 12, "collide_fix");
        wait_idle("collide_idle");
        check("collide_drain", exp_q.size(), 0);

        // Fill all digits with 0.
        for (int n = 0; n < 6; n++) begin
            push_exp(n, 7'h40);
            write_req(0, n[2:0], 4'h0);
            wait_idle("fill_idle");
        end
        check("fill_drain", exp_q.size(), 0);

`ifdef HEX_BLANK_EN
        push_exp(5, 7'h79);
        write_req(0, 3'd5, 4'h1);
        wait_idle("blank_pre_idle");
        push_exp(5, 7'h7F);
        @(negedge CLOCK_50);
        blank_mask = 6'b100000;
        wait_hex(5, 7'h7F, 13, "blank_on");
        wait_idle("blank_on_idle");
        push_exp(5, 7'h79);
        @(negedge CLOCK_50);
        blank_mask = 6'b000000;
        wait_hex(5, 7'h79, 13, "blank_off");
        wait_idle("blank_off_idle");
        check("blank_drain", exp_q.size(), 0);
`endif

        // Reset mid-scan: three same-value writes keep displays steady, then
        // reset must blank everything on the next edge.
        write_req(0, 3'd0, 4'h0);
        write_req(0, 3'd1, 4'h0);
        write_req(0, 3'd2, 4'h0);
        @(negedge CLOCK_50); #1;
        check("midscan_busy", busy, 1);
        reset = 1'b1;
        @(negedge CLOCK_50); #1;
        for (int n = 0; n < 6; n++) check($sformatf("midscan_hex%0d", n), hex_of(n), 7'h7F);
        check("midscan_busy_after", busy, 0);
        @(negedge CLOCK_50);
        reset = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        #1;
        check("post_reset_busy", busy, 0);
        check("final_drain", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
